// File: rtl/jmp_rvs.sv
// jmp_rvs: in-order reservation station feeding the branch/jump unit.
// Holds dispatched branch/JAL/JALR ops in a circular FIFO, snoops the CDB
// to wake up missing operands, and issues only from the head.
// Optional build macro: JMP_RVS_DISP_BYPASS_EN (capture a same-cycle CDB
// broadcast at dispatch instead of stalling dispatch for that cycle).
module jmp_rvs #(
  parameter int TAG_W     = 4,
  parameter int ROB_DEPTH = 16,
  parameter int ROB_PTR_W = $clog2(ROB_DEPTH),
  parameter int DEPTH     = 4,
  parameter int PTR_W     = $clog2(DEPTH),
  parameter int OPC_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 disp_req,
  output logic                 disp_rdy,
  input  logic [OPC_W-1:0]     disp_opc,
  input  logic                 disp_src1_rdy,
  input  logic [TAG_W-1:0]     disp_src1_tag,
  input  logic [31:0]          disp_src1_val,
  input  logic                 disp_src2_rdy,
  input  logic [TAG_W-1:0]     disp_src2_tag,
  input  logic [31:0]          disp_src2_val,
  input  logic [11:0]          disp_offset,
  input  logic [TAG_W-1:0]     disp_tag,
  input  logic [ROB_PTR_W-1:0] disp_inst_id,
  input  logic                 cdb_req,
  input  logic [TAG_W-1:0]     cdb_tag,
  input  logic [31:0]          cdb_wdata,
  input  logic                 flush,
  output logic                 iss_req,
  input  logic                 iss_rdy,
  output logic [OPC_W-1:0]     iss_opc,
  output logic [31:0]          iss_src1,
  output logic [31:0]          iss_src2,
  output logic [11:0]          iss_offset,
  output logic [TAG_W-1:0]     iss_tag,
  output logic [ROB_PTR_W-1:0] iss_inst_id,
  output logic [PTR_W:0]       occupancy
);

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [PTR_W:0]         wptr_reg, rptr_reg;
  logic [PTR_W-1:0]       wr_idx, head_idx;

  logic [DEPTH-1:0]       valid_reg, s1_rdy_reg, s2_rdy_reg;
  logic [TAG_W-1:0]       s1_tag_reg [DEPTH];
  logic [TAG_W-1:0]       s2_tag_reg [DEPTH];
  logic [31:0]            s1_val_reg [DEPTH];
  logic [31:0]            s2_val_reg [DEPTH];
  logic [OPC_W-1:0]       opc_reg    [DEPTH];
  logic [11:0]            offset_reg [DEPTH];
  logic [TAG_W-1:0]       tag_reg    [DEPTH];
  logic [ROB_PTR_W-1:0]   inst_id_reg[DEPTH];

  logic                   full, accept, pop, cdb_live;
  logic                   disp_hit1, disp_hit2, cap1, cap2;
  logic                   new_s1_rdy, new_s2_rdy;
  logic [31:0]            new_s1_val, new_s2_val;
  logic [DEPTH-1:0]       wake1, wake2, wr_sel, pop_sel;

  assign wr_idx    = wptr_reg[PTR_W-1:0];
  assign head_idx  = rptr_reg[PTR_W-1:0];
  assign full      = (wr_idx == head_idx) && (wptr_reg[PTR_W] != rptr_reg[PTR_W]);
  assign occupancy = wptr_reg - rptr_reg;

  // Tag 0 is x0 and never carries a real result, so it never wakes anything.
  assign cdb_live  = cdb_req && (cdb_tag != '0);
  assign disp_hit1 = !disp_src1_rdy && cdb_live && (disp_src1_tag == cdb_tag);
  assign disp_hit2 = !disp_src2_rdy && cdb_live && (disp_src2_tag == cdb_tag);

`ifdef JMP_RVS_DISP_BYPASS_EN
  // The broadcast is captured into the new entry directly.
  assign cap1     = disp_hit1;
  assign cap2     = disp_hit2;
  assign disp_rdy = !full;
`else
  // Without capture, an op that would miss the live broadcast is held off
  // one cycle; on retry the dispatcher sees the value as ready.
  assign cap1     = 1'b0;
  assign cap2     = 1'b0;
  assign disp_rdy = !full && !(disp_req && (disp_hit1 || disp_hit2));
`endif

  assign new_s1_rdy = disp_src1_rdy || cap1;
  assign new_s2_rdy = disp_src2_rdy || cap2;
  assign new_s1_val = cap1 ? cdb_wdata : disp_src1_val;
  assign new_s2_val = cap2 ? cdb_wdata : disp_src2_val;

  assign accept = disp_req && disp_rdy && !flush;

  // Only the head may issue; a waiting head blocks all younger ops.
  assign iss_req     = valid_reg[head_idx] && s1_rdy_reg[head_idx] && s2_rdy_reg[head_idx];
  assign pop         = iss_req && iss_rdy;
  assign iss_opc     = opc_reg[head_idx];
  assign iss_src1    = s1_val_reg[head_idx];
  assign iss_src2    = s2_val_reg[head_idx];
  assign iss_offset  = offset_reg[head_idx];
  assign iss_tag     = tag_reg[head_idx];
  assign iss_inst_id = inst_id_reg[head_idx];

  // Per-entry wakeup, write-select and pop-select decode.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
    assign wake1[gi]   = valid_reg[gi] && !s1_rdy_reg[gi] && cdb_live && (s1_tag_reg[gi] == cdb_tag);
    assign wake2[gi]   = valid_reg[gi] && !s2_rdy_reg[gi] && cdb_live && (s2_tag_reg[gi] == cdb_tag);
    assign wr_sel[gi]  = accept && (wr_idx == PTR_W'(gi));
    assign pop_sel[gi] = pop && (head_idx == PTR_W'(gi));
  end

  // Pointer update; flush rewinds both pointers to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_reg <= '0;
      rptr_reg <= '0;
    end else if (flush) begin
      wptr_reg <= '0;
      rptr_reg <= '0;
    end else begin
      if (accept) wptr_reg <= wptr_reg + (PTR_W + 1)'(1);
      if (pop)    rptr_reg <= rptr_reg + (PTR_W + 1)'(1);
    end
  end

  // Entry storage: write on accept, clear on pop, capture operands on wakeup.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg  <= '0;
      s1_rdy_reg <= '0;
      s2_rdy_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        s1_tag_reg[i]  <= '0;
        s2_tag_reg[i]  <= '0;
        s1_val_reg[i]  <= '0;
        s2_val_reg[i]  <= '0;
        opc_reg[i]     <= '0;
        offset_reg[i]  <= '0;
        tag_reg[i]     <= '0;
        inst_id_reg[i] <= '0;
      end
    end else if (flush) begin
      valid_reg <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_sel[i]) begin
          valid_reg[i]   <= 1'b1;
          s1_rdy_reg[i]  <= new_s1_rdy;
          s2_rdy_reg[i]  <= new_s2_rdy;
          s1_tag_reg[i]  <= disp_src1_tag;
          s2_tag_reg[i]  <= disp_src2_tag;
          s1_val_reg[i]  <= new_s1_val;
          s2_val_reg[i]  <= new_s2_val;
          opc_reg[i]     <= disp_opc;
          offset_reg[i]  <= disp_offset;
          tag_reg[i]     <= disp_tag;
          inst_id_reg[i] <= disp_inst_id;
        end else begin
          if (pop_sel[i]) valid_reg[i] <= 1'b0;
          if (wake1[i]) begin
            s1_rdy_reg[i] <= 1'b1;
            s1_val_reg[i] <= cdb_wdata;
          end
          if (wake2[i]) begin
            s2_rdy_reg[i] <= 1'b1;
            s2_val_reg[i] <= cdb_wdata;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_jmp_rvs.sv
// tb_jmp_rvs: scoreboard bench for jmp_rvs. A queue holds the ops the
// station should contain, in program order, with operands resolved as CDB
// broadcasts arrive; a negedge monitor checks the DUT against it.
module tb_jmp_rvs;
  localparam int TAG_W = 4, ROB_PTR_W = 4, DEPTH = 4, PTR_W = 2, OPC_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic disp_req, disp_rdy, disp_src1_rdy, disp_src2_rdy;
  logic [OPC_W-1:0] disp_opc;
  logic [TAG_W-1:0] disp_src1_tag, disp_src2_tag, disp_tag;
  logic [31:0] disp_src1_val, disp_src2_val;
  logic [11:0] disp_offset;
  logic [ROB_PTR_W-1:0] disp_inst_id;
  logic cdb_req, flush, iss_req, iss_rdy;
  logic [TAG_W-1:0] cdb_tag, iss_tag;
  logic [31:0] cdb_wdata, iss_src1, iss_src2;
  logic [OPC_W-1:0] iss_opc;
  logic [11:0] iss_offset;
  logic [ROB_PTR_W-1:0] iss_inst_id;
  logic [PTR_W:0] occupancy;

  jmp_rvs dut (
    .clk(clk), .rst(rst),
    .disp_req(disp_req), .disp_rdy(disp_rdy), .disp_opc(disp_opc),
    .disp_src1_rdy(disp_src1_rdy), .disp_src1_tag(disp_src1_tag), .disp_src1_val(disp_src1_val),
    .disp_src2_rdy(disp_src2_rdy), .disp_src2_tag(disp_src2_tag), .disp_src2_val(disp_src2_val),
    .disp_offset(disp_offset), .disp_tag(disp_tag), .disp_inst_id(disp_inst_id),
    .cdb_req(cdb_req), .cdb_tag(cdb_tag), .cdb_wdata(cdb_wdata), .flush(flush),
    .iss_req(iss_req), .iss_rdy(iss_rdy), .iss_opc(iss_opc), .iss_src1(iss_src1),
    .iss_src2(iss_src2), .iss_offset(iss_offset), .iss_tag(iss_tag),
    .iss_inst_id(iss_inst_id), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OPC_W-1:0] opc;
    bit r1; logic [TAG_W-1:0] t1; logic [31:0] v1;
    bit r2; logic [TAG_W-1:0] t2; logic [31:0] v2;
    logic [11:0] off; logic [TAG_W-1:0] tag; logic [ROB_PTR_W-1:0] id;
  } ent_t;

  ent_t sb[$];
  int tests = 0;
  int fails = 0;
  int issued_cnt = 0;
  bit acc_nb = 1'b0;
  logic [ROB_PTR_W-1:0] next_id = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: checks handshake-visible outputs against the model and pops
  // the expected op whenever the DUT completes an issue handshake.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      bit hit, exp_rdy, exp_req;
      ent_t e;
      hit = cdb_req && (cdb_tag != 0) &&
            ((!disp_src1_rdy && disp_src1_tag == cdb_tag) ||
             (!disp_src2_rdy && disp_src2_tag == cdb_tag));
      exp_rdy = (sb.size() < DEPTH);
`ifndef JMP_RVS_DISP_BYPASS_EN
      if (disp_req && hit) exp_rdy = 1'b0;
`endif
      exp_req = (sb.size() > 0) && sb[0].r1 && sb[0].r2;
      check("occupancy", 64'(occupancy), 64'(sb.size()));
      check("disp_rdy", 64'(disp_rdy), 64'(exp_rdy));
      check("iss_req", 64'(iss_req), 64'(exp_req));
      acc_nb = disp_req && exp_rdy && !flush;
      if (iss_req && iss_rdy) begin
        check("issue_nonempty", 64'(sb.size() != 0), 64'(1));
        if (sb.size() != 0) begin
          e = sb.pop_front();
          issued_cnt++;
          $display("[TB] issue id=%0d opc=%0h src1=%0h src2=%0h off=%0h tag=%0d",
                   iss_inst_id, iss_opc, iss_src1, iss_src2, iss_offset, iss_tag);
          check("iss_opc", 64'(iss_opc), 64'(e.opc));
          check("iss_src1", 64'(iss_src1), 64'(e.v1));
          check("iss_src2", 64'(iss_src2), 64'(e.v2));
          check("iss_offset", 64'(iss_offset), 64'(e.off));
          check("iss_tag", 64'(iss_tag), 64'(e.tag));
          check("iss_inst_id", 64'(iss_inst_id), 64'(e.id));
        end
      end
    end
  end

  // Reference model: at each edge apply flush, CDB wakeup and accept.
  initial forever begin
    @(posedge clk);
    if (rst || flush) begin
      sb.delete();
    end else begin
      if (cdb_req && cdb_tag != 0) begin
        foreach (sb[i]) begin
          if (!sb[i].r1 && sb[i].t1 == cdb_tag) begin sb[i].r1 = 1'b1; sb[i].v1 = cdb_wdata; end
          if (!sb[i].r2 && sb[i].t2 == cdb_tag) begin sb[i].r2 = 1'b1; sb[i].v2 = cdb_wdata; end
        end
      end
      if (acc_nb) begin
        ent_t n;
        n.opc = disp_opc; n.off = disp_offset; n.tag = disp_tag; n.id = disp_inst_id;
        n.r1 = disp_src1_rdy; n.t1 = disp_src1_tag; n.v1 = disp_src1_val;
        n.r2 = disp_src2_rdy; n.t2 = disp_src2_tag; n.v2 = disp_src2_val;
`ifdef JMP_RVS_DISP_BYPASS_EN
        if (cdb_req && cdb_tag != 0) begin
          if (!n.r1 && n.t1 == cdb_tag) begin n.r1 = 1'b1; n.v1 = cdb_wdata; end
          if (!n.r2 && n.t2 == cdb_tag) begin n.r2 = 1'b1; n.v2 = cdb_wdata; end
        end
`endif
        sb.push_back(n);
      end
    end
    acc_nb = 1'b0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    disp_req = 1'b0; cdb_req = 1'b0; flush = 1'b0;
  endtask

  task automatic disp(input logic [OPC_W-1:0] opc,
                      input bit r1, input logic [TAG_W-1:0] t1, input logic [31:0] v1,
                      input bit r2, input logic [TAG_W-1:0] t2, input logic [31:0] v2);
    disp_req = 1'b1; disp_opc = opc;
    disp_src1_rdy = r1; disp_src1_tag = t1; disp_src1_val = v1;
    disp_src2_rdy = r2; disp_src2_tag = t2; disp_src2_val = v2;
    disp_offset = 12'($urandom); disp_tag = TAG_W'($urandom);
    disp_inst_id = next_id; next_id = next_id + 1'b1;
  endtask

  initial begin
    int base;
    idle();
    iss_rdy = 1'b0; disp_opc = '0; disp_offset = '0; disp_tag = '0; disp_inst_id = '0;
    disp_src1_rdy = 1'b0; disp_src1_tag = '0; disp_src1_val = '0;
    disp_src2_rdy = 1'b0; disp_src2_tag = '0; disp_src2_val = '0;
    cdb_tag = '0; cdb_wdata = '0;
    #2;
    check("rst_occupancy", 64'(occupancy), 64'(0));
    check("rst_iss_req", 64'(iss_req), 64'(0));
    check("rst_disp_rdy", 64'(disp_rdy), 64'(1));
    check("rst_iss_src1", 64'(iss_src1), 64'(0));
    check("rst_iss_inst_id", 64'(iss_inst_id), 64'(0));
    tick();
    rst = 1'b0;
    tick();

    // Dispatch-to-issue latency of one cycle.
    disp(4'h0, 1, 0, 32'd5, 1, 0, 32'd5); iss_rdy = 1'b1;
    tick(); idle();
    check("t1_iss_req", 64'(iss_req), 64'(1));
    check("t1_iss_src1", 64'(iss_src1), 64'(5));
    check("t1_occ", 64'(occupancy), 64'(1));
    tick();
    check("t1_occ_after", 64'(occupancy), 64'(0));

    // Full station rejects dispatch even in a popping cycle.
    iss_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      disp(4'h1, 1, 0, $urandom, 1, 0, $urandom); tick();
    end
    disp(4'h2, 1, 0, 32'h77, 1, 0, 32'h88); iss_rdy = 1'b1; #1;
    check("t2_full_occ", 64'(occupancy), 64'(4));
    check("t2_full_rdy", 64'(disp_rdy), 64'(0));
    tick(); iss_rdy = 1'b0; #1;
    check("t2_after_pop_occ", 64'(occupancy), 64'(3));
    check("t2_retry_rdy", 64'(disp_rdy), 64'(1));
    tick(); idle();
    check("t2_retry_occ", 64'(occupancy), 64'(4));
    iss_rdy = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("t2_drain", 64'(occupancy), 64'(0));

    // Head waiting on tag 3 blocks a ready younger op.
    disp(4'h3, 0, 4'd3, 0, 1, 0, 32'd9); tick();
    disp(4'h4, 1, 0, 32'd1, 1, 0, 32'd2); tick(); idle();
    check("t3_blocked", 64'(iss_req), 64'(0));
    tick();
    check("t3_blocked2", 64'(iss_req), 64'(0));
    cdb_req = 1'b1; cdb_tag = 4'd3; cdb_wdata = 32'h40;
    tick(); idle();
    check("t3_head_req", 64'(iss_req), 64'(1));
    check("t3_head_src1", 64'(iss_src1), 64'h40);
    check("t3_head_opc", 64'(iss_opc), 64'h3);
    tick();
    check("t3_young_opc", 64'(iss_opc), 64'h4);
    tick();

    // Tag 0 broadcast never wakes.
    disp(4'h5, 0, 4'd0, 0, 0, 4'd0, 0); tick(); idle();
    cdb_req = 1'b1; cdb_tag = 4'd0; cdb_wdata = 32'hFFFF_FFFF;
    tick(); idle();
    check("t4_no_wake", 64'(iss_req), 64'(0));
    flush = 1'b1; tick(); idle();

    // Flush drops entries and the same-cycle dispatch.
    iss_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin disp(4'h6, 1, 0, $urandom, 1, 0, $urandom); tick(); end
    disp(4'h7, 1, 0, 1, 1, 0, 2); flush = 1'b1;
    tick(); idle();
    check("t5_occ", 64'(occupancy), 64'(0));
    check("t5_iss_req", 64'(iss_req), 64'(0));
    tick();
    check("t5_absent", 64'(occupancy), 64'(0));

    // Dispatch racing a CDB broadcast of its own source tag.
    iss_rdy = 1'b1;
    disp(4'h8, 0, 4'd7, 0, 1, 0, 32'd1);
    cdb_req = 1'b1; cdb_tag = 4'd7; cdb_wdata = 32'h123;
`ifdef JMP_RVS_DISP_BYPASS_EN
    tick(); idle();
    check("t6_req", 64'(iss_req), 64'(1));
    check("t6_src1", 64'(iss_src1), 64'h123);
    tick();
`else
    #1;
    check("t6_rdy_low", 64'(disp_rdy), 64'(0));
    tick(); cdb_req = 1'b0;
    disp(4'h8, 1, 0, 32'h123, 1, 0, 32'd1);
    tick(); idle();
    check("t6_retry_req", 64'(iss_req), 64'(1));
    check("t6_retry_src1", 64'(iss_src1), 64'h123);
    tick();
`endif

    // Ten back-to-back ops wrap the pointers and issue in order.
    base = issued_cnt;
    for (int i = 0; i < 10; i++) begin disp(4'($urandom), 1, 0, $urandom, 1, 0, $urandom); tick(); end
    idle();
    for (int i = 0; i < 3; i++) tick();
    check("wrap_issued", 64'(issued_cnt - base), 64'(10));
    check("wrap_occ", 64'(occupancy), 64'(0));

    // Asynchronous reset in the middle of operation.
    iss_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin disp(4'h9, 1, 0, $urandom, 1, 0, $urandom); tick(); end
    idle(); #3; rst = 1'b1; #1;
    check("arst_occ", 64'(occupancy), 64'(0));
    check("arst_iss_req", 64'(iss_req), 64'(0));
    check("arst_disp_rdy", 64'(disp_rdy), 64'(1));
    check("arst_iss_opc", 64'(iss_opc), 64'(0));
    tick(); rst = 1'b0; tick();

    // Randomised traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) < 60)
        disp(4'($urandom), $urandom_range(0, 9) < 6, 4'($urandom_range(0, 7)), $urandom,
             $urandom_range(0, 9) < 6, 4'($urandom_range(0, 7)), $urandom);
      else disp_req = 1'b0;
      cdb_req = ($urandom_range(0, 1) == 1);
      cdb_tag = 4'($urandom_range(0, 7));
      cdb_wdata = $urandom;
      iss_rdy = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 99) < 3);
      tick();
    end
    idle(); flush = 1'b1; tick(); idle();
    check("final_occ", 64'(occupancy), 64'(0));
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
